kf6845_bus_interface: RTL and testbench
=======================================

# kf6845_bus_interface

CPU-side bus interface for the KF6845 CRTC. It synchronises the asynchronous 6800-style host bus (E, CS_N, RS, R_W) into the single system clock domain and holds the 5-bit address register. It sequences every host access into single-cycle, one-hot write strobes and level read selects. These drive the register blocks, including cursor start/end (R10/R11), cursor address (R14/R15) and light pen (R16/R17).

## Interface
Parameters:
- none

Ports:
- clock  in  1  system clock; all state on its rising edge
- reset  in  1  asynchronous, active-high reset
- CS_N  in  1  chip select, active low, asynchronous to clock
- E  in  1  host enable strobe, asynchronous
- RS  in  1  register select: 0 = address register, 1 = data register
- R_W  in  1  1 = read, 0 = write
- data_bus_in  in  8  host write data
- data_bus_out  out  8  host read data
- data_bus_io  out  1  1 = host data bus driven by this block
- internal_data_bus_in  in  8  read data returned by the selected register block
- internal_data_bus_out  out  8  latched write data to the register blocks
- write_register  out  16  one-hot write strobe, bit n = Rn
- read_cursor_h_register, read_cursor_l_register, read_light_pen_h_register, read_light_pen_l_register  out  1 each  read selects for R14, R15, R16, R17

## Operation
- Synchronisation:
  - E, CS_N, RS, R_W and data_bus_in each pass through a 2-flop synchroniser.
  - e_rise = e_sync & ~e_prev; e_fall = ~e_sync & e_prev.
- State machine IDLE / ACCESS / COMMIT:
  - IDLE -> ACCESS on e_rise with cs_sync = 0. On entry, capture acc_rs = rs_sync and acc_rw = rw_sync.
  - ACCESS -> COMMIT on e_fall when acc_rw = 0. Capture internal_data_bus_out <= data_sync.
  - ACCESS -> IDLE on e_fall when acc_rw = 1.
  - ACCESS -> IDLE with no commit if cs_sync = 1 on any cycle in ACCESS (abort).
  - COMMIT -> IDLE unconditionally after one cycle.
  - e_rise while in ACCESS or COMMIT is ignored.
- COMMIT actions:
  - acc_rs = 0: address_register <= internal_data_bus_out[4:0].
  - acc_rs = 1 and address_register <= 15: write_register[address_register] = 1 for that one cycle.
  - acc_rs = 1 and address_register in 16..31: no strobe; the write is silently dropped.
  - Outside COMMIT, write_register = 16'h0000.
- ACCESS read actions (acc_rw = 1):
  - data_bus_io = 1.
  - If acc_rs = 1 and the address is 14..17, assert the matching read select for every ACCESS cycle.
  - data_bus_out is registered each cycle in ACCESS:
    - internal_data_bus_in when a read select is active;
    - 8'h00 for any other data register (write-only or unimplemented);
    - 8'h00 for the address register (RS = 0).
- Reads have no side effects. The address register does not auto-increment.
- Reset values:
  - state = IDLE; address_register = 0.
  - data_bus_out = 8'h00; data_bus_io = 0.
  - internal_data_bus_out = 8'h00; write_register = 0.
  - All read selects = 0; all synchroniser flops = 0, except CS_N sync = 1.
- Reset asserted mid-access: immediate return to IDLE, no strobe emitted, address_register cleared.

## Timing
- Edges are numbered relative to E transitions:
  - E rises before clock edge k: e_rise is seen after edge k+1; state = ACCESS after edge k+2.
  - E falls before clock edge m: e_fall is seen after edge m+1; state = COMMIT after edge m+2.
- Strobes and enables:
  - write_register is high for exactly one clock, edge m+2 to m+3; IDLE follows from m+3.
  - Read selects and data_bus_io are high from edge k+2 to m+2.
  - data_bus_out is valid from edge k+3.
- Host constraints:
  - E high for at least 4 clocks; E low for at least 3 clocks between accesses.
  - data_bus_in, RS, R_W and CS_N stable from E rise until 2 clocks after E falls.
- The minimum back-to-back access period is 7 clocks. No access is lost when the host meets these constraints.

## Test plan
- Reset:
  - Stimulus: assert reset with E high mid-access.
  - Required: state returns to IDLE; all outputs at reset values; no write_register pulse.
- Address write then data write:
  - Stimulus: RS=0 write 0x0E, then RS=1 write 0x12.
  - Required: write_register = 16'h4000 for exactly one clock, at edge m+2 of the second access; internal_data_bus_out = 0x12.
- Cursor read:
  - Stimulus: address 0x0F, RS=1 read, internal_data_bus_in = 0xA5.
  - Required: read_cursor_l_register high throughout ACCESS; data_bus_io = 1; data_bus_out = 0xA5; write_register stays 0.
- Out-of-range and write-only access:
  - Stimulus: write to address 0x11; read address 0x0A.
  - Required: no strobe for the write; the read returns 0x00 with no read select asserted.
- CS abort:
  - Stimulus: CS_N rises 1 clock after ACCESS is entered during a write.
  - Required: return to IDLE with no strobe; address_register unchanged.
- Back-to-back:
  - Stimulus: writes to R10 then R11 at the 7-clock minimum period.
  - Required: two single-cycle strobes, 16'h0400 then 16'h0800, with the correct data for each; none dropped.

Source files
------------

// File: rtl/kf6845_bus_interface_if.sv
// KF6845 host bus bundle: 6800-style E/CS_N/RS/R_W strobes
// and the split 8-bit host data bus.
interface kf6845_bus_interface_if;
  logic       CS_N;
  logic       E;
  logic       RS;
  logic       R_W;
  logic [7:0] data_bus_in;
  logic [7:0] data_bus_out;
  logic       data_bus_io;

  modport master (
    output CS_N, E, RS, R_W, data_bus_in,
    input  data_bus_out, data_bus_io
  );

  modport slave (
    input  CS_N, E, RS, R_W, data_bus_in,
    output data_bus_out, data_bus_io
  );
endinterface

// File: rtl/kf6845_bus_interface.sv
// KF6845 CRTC host bus interface: synchronises the host bus,
// holds the address register, emits write strobes / read selects.
module kf6845_bus_interface (
  input  logic        clock,
  input  logic        reset,
  kf6845_bus_interface_if.slave bus,
  input  logic [7:0]  internal_data_bus_in,
  output logic [7:0]  internal_data_bus_out,
  output logic [15:0] write_register,
  output logic        read_cursor_h_register,
  output logic        read_cursor_l_register,
  output logic        read_light_pen_h_register,
  output logic        read_light_pen_l_register
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    COMMIT = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic       e_s1_q, e_sync_q, e_prev_q;
  logic       cs_s1_q, cs_sync_q;
  logic       rs_s1_q, rs_sync_q;
  logic       rw_s1_q, rw_sync_q;
  logic [7:0] data_s1_q, data_sync_q;

  logic       acc_rs_q, acc_rs_d;
  logic       acc_rw_q, acc_rw_d;
  logic [4:0] addr_q, addr_d;
  logic [7:0] idbo_q, idbo_d;
  logic [7:0] dbo_q, dbo_d;

  logic       e_rise, e_fall;
  logic       rd_en, sel_any;

  // Two-flop synchronisers; CS_N idles deasserted
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      e_s1_q      <= 1'b0;
      e_sync_q    <= 1'b0;
      e_prev_q    <= 1'b0;
      cs_s1_q     <= 1'b1;
      cs_sync_q   <= 1'b1;
      rs_s1_q     <= 1'b0;
      rs_sync_q   <= 1'b0;
      rw_s1_q     <= 1'b0;
      rw_sync_q   <= 1'b0;
      data_s1_q   <= 8'h00;
      data_sync_q <= 8'h00;
    end else begin
      e_s1_q      <= bus.E;
      e_sync_q    <= e_s1_q;
      e_prev_q    <= e_sync_q;
      cs_s1_q     <= bus.CS_N;
      cs_sync_q   <= cs_s1_q;
      rs_s1_q     <= bus.RS;
      rs_sync_q   <= rs_s1_q;
      rw_s1_q     <= bus.R_W;
      rw_sync_q   <= rw_s1_q;
      data_s1_q   <= bus.data_bus_in;
      data_sync_q <= data_s1_q;
    end
  end

  assign e_rise = e_sync_q & ~e_prev_q;
  assign e_fall = ~e_sync_q & e_prev_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (e_rise && !cs_sync_q) state_d = ACCESS;
      end
      ACCESS: begin
        if (cs_sync_q) begin
          state_d = IDLE;
        end else if (e_fall) begin
          state_d = acc_rw_q ? IDLE : COMMIT;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    write_register            = 16'h0000;
    rd_en                     = 1'b0;
    read_cursor_h_register    = 1'b0;
    read_cursor_l_register    = 1'b0;
    read_light_pen_h_register = 1'b0;
    read_light_pen_l_register = 1'b0;
    if (state_q == COMMIT && acc_rs_q && !addr_q[4]) begin
      write_register = 16'h0001 << addr_q[3:0];
    end
    rd_en = (state_q == ACCESS) & acc_rw_q & acc_rs_q;
    read_cursor_h_register    = rd_en & (addr_q == 5'd14);
    read_cursor_l_register    = rd_en & (addr_q == 5'd15);
    read_light_pen_h_register = rd_en & (addr_q == 5'd16);
    read_light_pen_l_register = rd_en & (addr_q == 5'd17);
  end

  assign sel_any = read_cursor_h_register
                 | read_cursor_l_register
                 | read_light_pen_h_register
                 | read_light_pen_l_register;

  always_comb begin
    acc_rs_d = acc_rs_q;
    acc_rw_d = acc_rw_q;
    addr_d   = addr_q;
    idbo_d   = idbo_q;
    dbo_d    = dbo_q;
    if (state_q == IDLE && state_d == ACCESS) begin
      acc_rs_d = rs_sync_q;
      acc_rw_d = rw_sync_q;
    end
    if (state_q == ACCESS && state_d == COMMIT) begin
      idbo_d = data_sync_q;
    end
    if (state_q == COMMIT && !acc_rs_q) begin
      addr_d = idbo_q[4:0];
    end
    // Unreadable registers and the address register read as zero
    if (state_q == ACCESS) begin
      dbo_d = sel_any ? internal_data_bus_in : 8'h00;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_rs_q <= 1'b0;
      acc_rw_q <= 1'b0;
      addr_q   <= 5'd0;
      idbo_q   <= 8'h00;
      dbo_q    <= 8'h00;
    end else begin
      acc_rs_q <= acc_rs_d;
      acc_rw_q <= acc_rw_d;
      addr_q   <= addr_d;
      idbo_q   <= idbo_d;
      dbo_q    <= dbo_d;
    end
  end

  assign internal_data_bus_out = idbo_q;
  assign bus.data_bus_out      = dbo_q;
  assign bus.data_bus_io       = (state_q == ACCESS) & acc_rw_q;

endmodule

// File: tb/tb_kf6845_bus_interface.sv
// Directed bench for kf6845_bus_interface: host accesses driven
// on the falling clock edge, outputs sampled 1 ns after rising edges.
module tb_kf6845_bus_interface;

  logic        clk;
  logic        rst;
  logic [7:0]  idbi;
  logic [7:0]  idbo;
  logic [15:0] wr;
  logic        cur_h, cur_l, lp_h, lp_l;
  logic [3:0]  sel;
  int          tests;
  int          fails;
  int          pulses;
  int          p0;

  kf6845_bus_interface_if bus ();

  kf6845_bus_interface dut (
    .clock                     (clk),
    .reset                     (rst),
    .bus                       (bus),
    .internal_data_bus_in      (idbi),
    .internal_data_bus_out     (idbo),
    .write_register            (wr),
    .read_cursor_h_register    (cur_h),
    .read_cursor_l_register    (cur_l),
    .read_light_pen_h_register (lp_h),
    .read_light_pen_l_register (lp_l)
  );

  assign sel = {cur_h, cur_l, lp_h, lp_l};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (wr != 16'h0000) pulses++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One host access; E high 4 clocks. fast=1 leaves E low
  // only 3 clocks before the next call (7-clock period).
  task automatic acc(input logic        rs,
                     input logic        rw,
                     input logic [7:0]  din,
                     input logic [15:0] exp_wr,
                     input logic [7:0]  exp_dout,
                     input logic [3:0]  exp_sel,
                     input bit          fast);
    @(negedge clk);
    bus.CS_N        = 1'b0;
    bus.RS          = rs;
    bus.R_W         = rw;
    bus.data_bus_in = din;
    bus.E           = 1'b1;
    @(posedge clk); #1;
    chk("wr_idle_k", wr, 16'h0000);
    @(posedge clk);
    @(posedge clk); #1;
    chk("io_k2", {15'd0, bus.data_bus_io}, {15'd0, rw});
    chk("sel_k2", {12'd0, sel}, {12'd0, exp_sel});
    chk("wr_k2", wr, 16'h0000);
    @(posedge clk); #1;
    if (rw) chk("dout_k3", {8'd0, bus.data_bus_out},
                {8'd0, exp_dout});
    @(negedge clk);
    bus.E = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("sel_m1", {12'd0, sel}, {12'd0, exp_sel});
    chk("wr_m1", wr, 16'h0000);
    @(posedge clk); #1;
    chk("wr_m2", wr, exp_wr);
    chk("io_m2", {15'd0, bus.data_bus_io}, 16'd0);
    chk("sel_m2", {12'd0, sel}, 16'd0);
    if (!rw) chk("idbo_m2", {8'd0, idbo}, {8'd0, din});
    if (!fast) begin
      @(posedge clk); #1;
      chk("wr_m3", wr, 16'h0000);
    end
  endtask

  initial begin
    tests           = 0;
    fails           = 0;
    pulses          = 0;
    rst             = 1'b1;
    bus.CS_N        = 1'b1;
    bus.E           = 1'b0;
    bus.RS          = 1'b0;
    bus.R_W         = 1'b0;
    bus.data_bus_in = 8'h00;
    idbi            = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr", wr, 16'h0000);
    chk("rst_io", {15'd0, bus.data_bus_io}, 16'd0);
    chk("rst_dout", {8'd0, bus.data_bus_out}, 16'd0);
    chk("rst_idbo", {8'd0, idbo}, 16'd0);
    chk("rst_sel", {12'd0, sel}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    acc(0, 0, 8'h0E, 16'h0000, 8'h00, 4'b0000, 0);
    acc(1, 0, 8'h12, 16'h4000, 8'h00, 4'b0000, 0);

    acc(0, 0, 8'h0F, 16'h0000, 8'h00, 4'b0000, 0);
    acc(1, 1, 8'h00, 16'h0000, 8'hA5, 4'b0100, 0);

    acc(0, 0, 8'h11, 16'h0000, 8'h00, 4'b0000, 0);
    p0 = pulses;
    acc(1, 0, 8'h33, 16'h0000, 8'h00, 4'b0000, 0);
    chk("oor_pulses", 16'(pulses), 16'(p0));
    acc(0, 1, 8'h00, 16'h0000, 8'h00, 4'b0000, 0);
    acc(0, 0, 8'h0A, 16'h0000, 8'h00, 4'b0000, 0);
    acc(1, 1, 8'h00, 16'h0000, 8'h00, 4'b0000, 0);

    idbi = 8'h3C;
    acc(0, 0, 8'h10, 16'h0000, 8'h00, 4'b0000, 0);
    acc(1, 1, 8'h00, 16'h0000, 8'h3C, 4'b0010, 0);
    acc(0, 0, 8'h0E, 16'h0000, 8'h00, 4'b0000, 0);
    acc(1, 1, 8'h00, 16'h0000, 8'h3C, 4'b1000, 0);

    p0 = pulses;
    @(negedge clk);
    bus.CS_N        = 1'b0;
    bus.RS          = 1'b0;
    bus.R_W         = 1'b0;
    bus.data_bus_in = 8'h03;
    bus.E           = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.CS_N = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.E = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.CS_N = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_pulses", 16'(pulses), 16'(p0));
    acc(1, 0, 8'h55, 16'h4000, 8'h00, 4'b0000, 0);

    acc(0, 0, 8'h0A, 16'h0000, 8'h00, 4'b0000, 1);
    acc(1, 0, 8'h21, 16'h0400, 8'h00, 4'b0000, 1);
    acc(0, 0, 8'h0B, 16'h0000, 8'h00, 4'b0000, 1);
    acc(1, 0, 8'h42, 16'h0800, 8'h00, 4'b0000, 0);

    acc(0, 0, 8'h0E, 16'h0000, 8'h00, 4'b0000, 0);
    p0 = pulses;
    @(negedge clk);
    bus.CS_N        = 1'b0;
    bus.RS          = 1'b1;
    bus.R_W         = 1'b0;
    bus.data_bus_in = 8'h77;
    bus.E           = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_wr", wr, 16'h0000);
    chk("mid_rst_idbo", {8'd0, idbo}, 16'd0);
    chk("mid_rst_dout", {8'd0, bus.data_bus_out}, 16'd0);
    chk("mid_rst_io", {15'd0, bus.data_bus_io}, 16'd0);
    @(negedge clk);
    bus.E = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_rst_pulses", 16'(pulses), 16'(p0));
    acc(1, 0, 8'h99, 16'h0001, 8'h00, 4'b0000, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
